nmt_mem_arbiter: RTL and testbench
==================================

Name: nmt_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port data memory between NUM_REQ near-memory-thread (NMT) MEM stages. Used for the shared matrix/vector region.
- Accepts one load or store per cycle through a valid/ready handshake and issues it to the memory as a registered command.
- Routes each response back to the requester that issued it.
- Supports a short lock so one thread can complete a read-modify-write update atomically.

Parameters:
- NUM_REQ, 4, number of NMT requesters (2..8).
- ADDR_W, 9, word address width.
- DATA_W, 32, data word width.
- MAX_HOLD, 8, maximum number of cycles a lock may be held before it is forcibly released.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_we  in  NUM_REQ  1 = store, 0 = load.
- req_lock  in  NUM_REQ  keep the grant after this transfer.
- req_addr  in  NUM_REQ*ADDR_W  packed word addresses; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed store data.
- req_ready  out  NUM_REQ  combinational grant, at most one bit high (one-hot or zero).
- rsp_valid  out  NUM_REQ  registered one-cycle response pulse.
- rsp_rdata  out  DATA_W  registered load data; 0 for stores.
- mem_en  out  1  registered memory command strobe.
- mem_we  out  1  registered store enable.
- mem_addr  out  ADDR_W  registered memory address.
- mem_wdata  out  DATA_W  registered store data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en.
- lock_timeout  out  1  sticky flag: a lock was forcibly released.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, state = ARB, pointer ptr = 0, hold counter = 0, in-flight pipeline cleared.
- Releasing reset mid-transaction drops all in-flight operations; no rsp_valid is produced for them.
- A transfer occurs for requester i when req_valid[i] and req_ready[i] are both high before a rising edge. Maximum one transfer per cycle.
- State ARB:
  - req_ready goes to the first requester with valid set, searching ptr, ptr+1, ... with wrap modulo NUM_REQ.
  - On a transfer with req_lock=0: ptr becomes (i+1) mod NUM_REQ.
  - On a transfer with req_lock=1: owner = i, hold counter = 0, go to LOCKED; ptr is unchanged.
- State LOCKED:
  - Only the owner can be granted; req_ready[owner] = req_valid[owner]; all other ready bits are 0.
  - The hold counter increments every cycle spent in LOCKED.
  - Owner transfer with req_lock=0: go to ARB, ptr = (owner+1) mod NUM_REQ.
  - Owner transfer with req_lock=1: stay in LOCKED.
  - Forced release: if the hold counter reaches MAX_HOLD-1 and no owner transfer occurs that cycle, go to ARB, ptr = (owner+1) mod NUM_REQ, and set lock_timeout to 1. lock_timeout clears only on reset.
  - If the owner transfers on the same cycle the counter reaches MAX_HOLD-1, the transfer is completed normally and the lock_timeout flag is not set; the transfer's req_lock decides the next state.
- Command pipeline (transfer at edge E0):
  - After E0: mem_en=1 for exactly one cycle, with mem_we, mem_addr and mem_wdata (0 on loads) from requester i. The id i is carried alongside.
  - If no transfer occurs at E0, mem_en=0; mem_addr and mem_wdata hold their previous values.
  - The memory samples the command at E1.
  - At E2: rsp_valid[i]=1 for one cycle and rsp_rdata = mem_rdata for a load, 0 for a store.
  - Response latency is fixed at 2 cycles after the handshake edge. Back-to-back transfers produce back-to-back responses, in order.
- rsp_valid is one-hot or zero. rsp_rdata is 0 when no response is pending.
- No address range checks; addresses pass through unmodified at ADDR_W bits.
- Stores and loads to the same address in consecutive cycles are ordered by issue order; the memory's read-after-write behaviour is outside this block.

Test Plan:
- Single load: reset, memory preloaded with word 80 = 0x3; req 2 issues a load of addr 80 → req_ready[2] high in the same cycle; mem_en=1 with mem_addr=80 one cycle later; rsp_valid[2]=1 and rsp_rdata=0x3 two cycles after the handshake edge.
- All-valid fairness: all four requesters hold valid for 8 cycles → grant order 0,1,2,3,0,1,2,3, one per cycle; each requester gets 2 responses.
- Lock read-modify-write: req 1 loads addr 100 with lock=1, then stores 0x5 to addr 100 with lock=0, while req 0 and req 3 hold valid → no grant to 0 or 3 until the store transfers; the next grant after the store goes to req 3 (ptr=2, req 2 idle); memory word 100 = 0x5.
- Lock timeout with MAX_HOLD=8: req 0 transfers with lock=1, then drops valid; req 2 holds valid → req 2 is granted exactly 8 cycles after the lock transfer; lock_timeout becomes 1 and stays 1.
- Store ack: req 3 stores 0xDEAD to addr 5 → mem_we=1, mem_wdata=0xDEAD; rsp_valid[3] pulses with rsp_rdata=0; a later load of addr 5 returns 0xDEAD.
- Reset mid-flight: assert rst_n=0 one cycle after a load handshake → all outputs go to 0 immediately; no rsp_valid after release; the first grant after release goes to the lowest-index valid requester (ptr=0).

Source files
------------

// File: rtl/nmt_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ NMT MEM stages,
// with a bounded per-thread lock so one thread can finish a read-modify-write atomically.
module nmt_mem_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic                      lock_timeout
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);

  typedef enum logic {ARB, LOCKED} state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  ptr_q;
  logic [IDX_W-1:0]  owner_q;
  logic [HOLD_W-1:0] hold_q;
  logic              lock_timeout_q;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [IDX_W-1:0]  id_q;

  logic              p2_valid_q;
  logic              p2_we_q;
  logic [IDX_W-1:0]  p2_id_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
    assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
  end

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] base, input int offs);
    int sum;
    sum = int'(base) + offs;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Search from ptr upward; iterating the offsets backwards lets the nearest valid win.
  logic [IDX_W-1:0] rr_idx;
  logic             rr_any;
  always_comb begin
    rr_idx = ptr_q;
    rr_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[next_idx(ptr_q, k)]) begin
        rr_idx = next_idx(ptr_q, k);
        rr_any = 1'b1;
      end
    end
  end

  logic [IDX_W-1:0] xfer_idx;
  logic             xfer;
  logic             hold_last;

  assign xfer_idx  = (state_q == LOCKED) ? owner_q : rr_idx;
  assign xfer      = rst_n && ((state_q == LOCKED) ? req_valid[owner_q] : rr_any);
  assign req_ready = xfer ? (NUM_REQ'(1) << xfer_idx) : '0;
  assign hold_last = (hold_q >= HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB;
      ptr_q          <= '0;
      owner_q        <= '0;
      hold_q         <= '0;
      lock_timeout_q <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (xfer) begin
            if (req_lock[xfer_idx]) begin
              state_q <= LOCKED;
              owner_q <= xfer_idx;
              hold_q  <= '0;
            end else begin
              ptr_q <= next_idx(xfer_idx, 1);
            end
          end
        end
        LOCKED: begin
          // Saturating so a lock renewed on its final cycle still expires next idle cycle.
          if (!hold_last) hold_q <= hold_q + HOLD_W'(1);
          if (xfer) begin
            if (!req_lock[owner_q]) begin
              state_q <= ARB;
              ptr_q   <= next_idx(owner_q, 1);
            end
          end else if (hold_last) begin
            state_q        <= ARB;
            ptr_q          <= next_idx(owner_q, 1);
            lock_timeout_q <= 1'b1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      id_q        <= '0;
      p2_valid_q  <= 1'b0;
      p2_we_q     <= 1'b0;
      p2_id_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      mem_en_q <= xfer;
      if (xfer) begin
        mem_we_q    <= req_we[xfer_idx];
        mem_addr_q  <= addr_arr[xfer_idx];
        mem_wdata_q <= req_we[xfer_idx] ? wdata_arr[xfer_idx] : '0;
        id_q        <= xfer_idx;
      end else begin
        mem_we_q <= 1'b0;
      end
      // The memory sees the command at the next edge; its read data is valid one cycle later.
      p2_valid_q  <= mem_en_q;
      p2_we_q     <= mem_we_q;
      p2_id_q     <= id_q;
      rsp_valid_q <= p2_valid_q ? (NUM_REQ'(1) << p2_id_q) : '0;
      rsp_rdata_q <= (p2_valid_q && !p2_we_q) ? mem_rdata : '0;
    end
  end

  assign mem_en       = mem_en_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign lock_timeout = lock_timeout_q;

endmodule

// File: tb/tb_nmt_mem_arbiter.sv
// Scoreboard bench for nmt_mem_arbiter: directed scenarios plus random traffic, checked
// against a queue-based reference model and a behavioural single-port RAM.
module tb_nmt_mem_arbiter;
  localparam int NR = 4;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int MH = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_we = '0;
  logic [NR-1:0]     req_lock = '0;
  logic [NR*AW-1:0]  req_addr = '0;
  logic [NR*DW-1:0]  req_wdata = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              lock_timeout;

  nmt_mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lock_timeout(lock_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM with registered read and a preload port.
  logic          pre_en = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            cyc;
    int            id;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t cmdq[$];
  exp_t rspq[$];

  // Reference model: issue-ordered memory image plus round-robin / lock bookkeeping.
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int  m_ptr = 0;
  bit  m_locked = 0;
  int  m_owner = 0;
  int  m_lock_cyc = 0;
  bit  m_timeout = 0;

  logic [AW-1:0] a_arr [NR];
  logic [DW-1:0] d_arr [NR];
  int dut_g;
  int rsp_cnt [NR];

  task automatic model_reset();
    m_ptr = 0;
    m_locked = 0;
    m_timeout = 0;
    cmdq.delete();
    rspq.delete();
  endtask

  task automatic step(input logic [NR-1:0] v, input logic [NR-1:0] w, input logic [NR-1:0] l);
    logic [NR-1:0] exp_rdy;
    int g;
    exp_t e;
    @(negedge clk);
    req_valid = v;
    req_we    = w;
    req_lock  = l;
    for (int i = 0; i < NR; i++) begin
      req_addr[i*AW +: AW]  = a_arr[i];
      req_wdata[i*DW +: DW] = d_arr[i];
    end
    #1;
    g = -1;
    if (m_locked) begin
      if (v[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < NR && g < 0; k++)
        if (v[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
    end
    exp_rdy = (g >= 0) ? NR'(1 << g) : '0;
    chk("req_ready", req_ready, exp_rdy);
    chk("lock_timeout", lock_timeout, m_timeout);
    dut_g = -1;
    for (int i = 0; i < NR; i++) if (req_ready[i] && v[i]) dut_g = i;
    if (g >= 0) begin
      e.id = g; e.we = w[g]; e.addr = a_arr[g];
      e.cyc = cyc + 1; e.data = w[g] ? d_arr[g] : '0;
      cmdq.push_back(e);
      e.cyc = cyc + 3; e.data = w[g] ? '0 : ref_mem[a_arr[g]];
      rspq.push_back(e);
      if (w[g]) ref_mem[a_arr[g]] = d_arr[g];
    end
    if (m_locked) begin
      if (g >= 0) begin
        if (!l[g]) begin m_locked = 0; m_ptr = (m_owner + 1) % NR; end
      end else if (cyc - m_lock_cyc >= MH) begin
        m_locked = 0; m_ptr = (m_owner + 1) % NR; m_timeout = 1;
      end
    end else if (g >= 0) begin
      if (l[g]) begin m_locked = 1; m_owner = g; m_lock_cyc = cyc; end
      else m_ptr = (g + 1) % NR;
    end
  endtask

  task automatic mon();
    exp_t e;
    logic en_exp;
    logic [NR-1:0] rv_exp;
    logic [DW-1:0] rd_exp;
    en_exp = (cmdq.size() > 0) && (cmdq[0].cyc == cyc);
    chk("mem_en", mem_en, en_exp);
    if (en_exp) begin
      e = cmdq.pop_front();
      chk("mem_we", mem_we, e.we);
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_wdata", mem_wdata, e.data);
    end
    rv_exp = '0;
    rd_exp = '0;
    if (rspq.size() > 0 && rspq[0].cyc == cyc) begin
      e = rspq.pop_front();
      rv_exp = NR'(1 << e.id);
      rd_exp = e.data;
    end
    chk("rsp_valid", rsp_valid, rv_exp);
    chk("rsp_rdata", rsp_rdata, rd_exp);
    for (int i = 0; i < NR; i++) if (rsp_valid[i]) rsp_cnt[i]++;
  endtask

  always @(negedge clk) if (rst_n) mon();

  task automatic check_all_zero(input string tag);
    chk({tag, "_mem_en"}, mem_en, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_lock_timeout"}, lock_timeout, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, '0);
  endtask

  initial begin
    int lock_c;
    for (int i = 0; i < NR; i++) begin a_arr[i] = '0; d_arr[i] = '0; rsp_cnt[i] = 0; end
    // Preload the RAM while reset is held, with valid requests that must not be granted.
    rst_n = 1'b0;
    req_valid = '1;
    for (int i = 0; i < (1 << AW); i++) begin
      @(negedge clk);
      pre_en = 1'b1;
      pre_addr = AW'(i);
      pre_data = (i == 80) ? 32'h3 : $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_en = 1'b0;
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    req_valid = '0;
    model_reset();

    // All-valid fairness: grants rotate 0,1,2,3,...
    for (int i = 0; i < NR; i++) a_arr[i] = AW'(10 + i);
    for (int k = 0; k < 8; k++) begin
      step('1, '0, '0);
      chk("fair_grant", dut_g, k % NR);
    end
    idle(3);
    for (int i = 0; i < NR; i++) chk("fair_rsp_count", rsp_cnt[i], 2);

    // Single load of word 80 by requester 2.
    a_arr[2] = 80;
    step(4'b0100, '0, '0);
    chk("single_load_grant", dut_g, 2);
    idle(3);

    // Locked read-modify-write by requester 1 while 0 and 3 wait.
    a_arr[1] = 100;
    step(4'b0010, '0, 4'b0010);
    chk("rmw_load_grant", dut_g, 1);
    step(4'b1001, '0, '0);
    chk("rmw_wait_grant", dut_g, -1);
    step(4'b1001, '0, '0);
    chk("rmw_wait_grant", dut_g, -1);
    d_arr[1] = 32'h5;
    step(4'b1011, 4'b0010, '0);
    chk("rmw_store_grant", dut_g, 1);
    step(4'b1001, '0, '0);
    chk("rmw_after_grant", dut_g, 3);
    idle(2);
    chk("rmw_mem_word", ram[100], 32'h5);

    // Lock timeout: requester 0 locks and goes idle; requester 2 waits.
    a_arr[0] = 40;
    step(4'b0001, '0, 4'b0001);
    chk("timeout_lock_grant", dut_g, 0);
    lock_c = cyc;
    for (int k = 0; k < 20; k++) begin
      a_arr[2] = 41;
      step(4'b0100, '0, '0);
      if (dut_g == 2) break;
    end
    chk("timeout_grant_delay", cyc - (lock_c + 1), MH);
    chk("timeout_flag", lock_timeout, 1);
    idle(3);
    chk("timeout_sticky", lock_timeout, 1);

    // Store acknowledge then read back.
    a_arr[3] = 5;
    d_arr[3] = 32'hDEAD;
    step(4'b1000, 4'b1000, '0);
    chk("store_grant", dut_g, 3);
    idle(3);
    step(4'b1000, '0, '0);
    idle(3);
    chk("store_mem_word", ram[5], 32'hDEAD);

    // Random traffic over a small address window to exercise same-address ordering.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NR; i++) begin
        a_arr[i] = AW'($urandom_range(0, 15));
        d_arr[i] = $urandom;
      end
      step(NR'($urandom), NR'($urandom), NR'($urandom & $urandom));
    end
    idle(MH + 4);

    // Reset one cycle after a load handshake: everything in flight is dropped.
    a_arr[0] = 20;
    step(4'b0001, '0, '0);
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    idle(4);
    step(4'b1010, '0, '0);
    chk("post_reset_grant", dut_g, 1);
    idle(4);
    chk("cmdq_drained", cmdq.size(), 0);
    chk("rspq_drained", rspq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
